bias_load_ctrl: RTL
===================

Name: bias_load_ctrl

Overview:
Sequencer for the bias selector. On a layer start it fetches bias words from the weight SRAM: one 25×4b word for CONV1, two words for CONV2. It pulses the matching load enables at the cycle the delayed SRAM data is present, then steps the bias channel index (set / conv1_bias_set) once per output channel as the conv engine reports completion. It sits between the top-level layer FSM, the weight SRAM read port and the bias selector.

Parameters:
CONV1_BIAS_ADDR, 17'd0, weight SRAM word address of the CONV1 bias word
CONV2_BIAS0_ADDR, 17'd1, address of the CONV2 biases 0..24
CONV2_BIAS1_ADDR, 17'd2, address of the CONV2 biases 25..49
CONV1_CH, 20, CONV1 output channels (≤25)
CONV2_CH, 50, CONV2 output channels (≤50)

Ports:
clk  in  1  clock
srst  in  1  synchronous reset, active-high
start  in  1  one-cycle layer start pulse, sampled only in IDLE
mode_in  in  2  requested layer: 1=CONV1, 2=CONV2
ch_advance  in  1  pulse: the conv engine finished the current output channel
mode  out  2  mode to the bias selector: 0 in IDLE, else the latched layer
sram_raddr_weight  out  17  weight SRAM read address
sram_rd_en  out  1  read strobe, high in issue states only
load_conv1_bias_enable  out  1  to the bias selector
load_conv2_bias0_enable  out  1  to the bias selector
load_conv2_bias1_enable  out  1  to the bias selector
conv1_bias_set  out  17  channel index, zero-extended, valid in CONV1
set  out  8  channel index, valid in CONV2
busy  out  1  high in every state except IDLE
bias_ready  out  1  the selector's bias_data matches the current index
done  out  1  one-cycle pulse after the last channel

Behaviour:
- Reset: state=IDLE. All outputs 0, channel counter 0, latched mode 0. srst in any state aborts immediately. In-flight SRAM data is ignored because no load enable fires.
- Timing facts: the SRAM returns data 1 cycle after the address. The selector registers rdata again, so a load enable must be asserted 2 cycles after the address cycle. The selector registers bias_data, so it is valid 1 cycle after an index change.
- IDLE: on start with mode_in∈{1,2}, latch the mode and clear the counter. start with mode_in∈{0,3} is ignored.
- CONV1 path: ISSUE (addr=CONV1_BIAS_ADDR, rd_en=1) → WAIT → LOAD (load_conv1_bias_enable=1) → SETTLE → RUN.
- CONV2 path: ISSUE0 (CONV2_BIAS0_ADDR) → ISSUE1 (CONV2_BIAS1_ADDR) → LOAD0 (bias0_enable) → LOAD1 (bias1_enable) → SETTLE → RUN.
- Latency: for the start cycle c0, bias_ready first rises at c5 for both paths.
- Load enables: exactly one-cycle pulses and mutually exclusive. sram_raddr_weight holds its last value outside issue states.
- RUN:
  - bias_ready=1 except in the cycle immediately after an index increment.
  - On ch_advance with counter<N-1 (N=CONV1_CH or CONV2_CH), increment the counter.
  - On ch_advance with counter==N-1, go to DONE.
- DONE: done=1 and mode held for one cycle; then IDLE, mode=0, counter=0.
- Ignored inputs: ch_advance outside RUN, and start while busy, are ignored with no state change.
- Index width: the counter is 8 bits; set=counter and conv1_bias_set={9'b0,counter}. The counter never wraps; the DONE transition precedes N.

Optional Feature:
BIAS_CTRL_ERR_EN: adds output err (1b), a sticky flag cleared only by srst. It sets on:
- ch_advance outside RUN;
- start while busy;
- start with an invalid mode_in.

Without the macro, the port is absent and these events are silently ignored as above.

Decomposition:
- Shared package: mode localparams (IDLE=0, CONV1=1, CONV2=2, DONE=3, shared with the bias selector), the controller state encoding, and the address and index widths (17, 8).
- One natural sub-module: bias_set_cnt, an 8-bit counter with clear, increment and last-channel compare against a runtime limit. The FSM stays in bias_load_ctrl.

Test Plan:
- CONV1 start at c0 (defaults) → rd_en/addr 0 at c1; load_conv1 at c3; bias_ready at c5. After 20 ch_advance pulses, done at the cycle after the 20th, then mode=0.
- CONV2 start → addrs 1,2 at c1,c2; bias0 enable c3; bias1 enable c4; bias_ready c5. Set reaches 49; the 50th ch_advance gives done.
- With a selector model, in RUN: ch_advance at set=7 → set=8 next cycle, bias_ready low 1 cycle, bias_data=box[8] the cycle after.
- start (mode_in=2) during CONV1 WAIT → ignored; the CONV1 sequence completes unchanged. err=1 with BIAS_CTRL_ERR_EN.
- srst asserted in LOAD0 → next cycle IDLE, all outputs 0. A fresh CONV1 start then behaves as in the first test.
- start with mode_in=3, and ch_advance in IDLE → busy stays 0 and no SRAM read occurs.

Source files
------------

// File: rtl/bias_load_ctrl_pkg.sv
// Shared definitions for the bias load sequencer and the bias selector.
// Mode codes, controller state encoding, address and channel-index widths.
package bias_load_ctrl_pkg;

    localparam int ADDR_W = 17;
    localparam int IDX_W  = 8;

    localparam logic [1:0] MODE_IDLE  = 2'd0;
    localparam logic [1:0] MODE_CONV1 = 2'd1;
    localparam logic [1:0] MODE_CONV2 = 2'd2;
    localparam logic [1:0] MODE_DONE  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_LOAD,
        S_ISSUE0,
        S_ISSUE1,
        S_LOAD0,
        S_LOAD1,
        S_SETTLE,
        S_RUN,
        S_DONE
    } state_t;

    function automatic logic mode_valid(input logic [1:0] m);
        return (m != MODE_IDLE) && (m != MODE_DONE);
    endfunction

endpackage

// File: rtl/bias_set_cnt.sv
// Output-channel index counter: clear, increment, and a last-channel flag
// against a runtime channel count.
module bias_set_cnt
    import bias_load_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             inc,
    input  logic [IDX_W-1:0] limit,
    output logic [IDX_W-1:0] count,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (srst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + IDX_W'(1);
        end
    end

    assign last = (count == (limit - IDX_W'(1)));

endmodule

// File: rtl/bias_load_ctrl.sv
// Bias load sequencer: fetches bias words from the weight SRAM on a layer start,
// pulses the selector load enables, then steps the channel index. Optional err flag: BIAS_CTRL_ERR_EN.
module bias_load_ctrl
    import bias_load_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] CONV1_BIAS_ADDR  = 17'd0,
    parameter logic [ADDR_W-1:0] CONV2_BIAS0_ADDR = 17'd1,
    parameter logic [ADDR_W-1:0] CONV2_BIAS1_ADDR = 17'd2,
    parameter int                CONV1_CH         = 20,
    parameter int                CONV2_CH         = 50
)
(
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [1:0]        mode_in,
    input  logic              ch_advance,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] sram_raddr_weight,
    output logic              sram_rd_en,
    output logic              load_conv1_bias_enable,
    output logic              load_conv2_bias0_enable,
    output logic              load_conv2_bias1_enable,
    output logic [ADDR_W-1:0] conv1_bias_set,
    output logic [IDX_W-1:0]  set,
    output logic              busy,
    output logic              bias_ready,
    output logic              done
`ifdef BIAS_CTRL_ERR_EN
    ,
    output logic              err
`endif
);

    localparam logic [IDX_W-1:0] CONV1_LIM = IDX_W'(CONV1_CH);
    localparam logic [IDX_W-1:0] CONV2_LIM = IDX_W'(CONV2_CH);

    state_t            state, next_state;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] addr_q, addr_now;
    logic              inc_d;
    logic              latch, cnt_clr, cnt_inc, cnt_last;
    logic [IDX_W-1:0]  count, limit;

    assign limit = (mode_q == MODE_CONV2) ? CONV2_LIM : CONV1_LIM;

    bias_set_cnt u_cnt (
        .clk   (clk),
        .srst  (srst),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .limit (limit),
        .count (count),
        .last  (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state  <= S_IDLE;
            mode_q <= MODE_IDLE;
            addr_q <= '0;
            inc_d  <= 1'b0;
        end else begin
            state  <= next_state;
            addr_q <= addr_now;
            inc_d  <= cnt_inc;
            if (latch) begin
                mode_q <= mode_in;
            end else if (state == S_DONE) begin
                mode_q <= MODE_IDLE;
            end
        end
    end

    always_comb begin
        next_state              = state;
        addr_now                = addr_q;
        sram_rd_en              = 1'b0;
        load_conv1_bias_enable  = 1'b0;
        load_conv2_bias0_enable = 1'b0;
        load_conv2_bias1_enable = 1'b0;
        latch                   = 1'b0;
        cnt_clr                 = 1'b0;
        cnt_inc                 = 1'b0;
        case (state)
            S_IDLE: begin
                if (start && mode_valid(mode_in)) begin
                    latch      = 1'b1;
                    cnt_clr    = 1'b1;
                    next_state = (mode_in == MODE_CONV1) ? S_ISSUE : S_ISSUE0;
                end
            end
            S_ISSUE: begin
                sram_rd_en = 1'b1;
                addr_now   = CONV1_BIAS_ADDR;
                next_state = S_WAIT;
            end
            S_WAIT:  next_state = S_LOAD;
            S_LOAD: begin
                load_conv1_bias_enable = 1'b1;
                next_state             = S_SETTLE;
            end
            S_ISSUE0: begin
                sram_rd_en = 1'b1;
                addr_now   = CONV2_BIAS0_ADDR;
                next_state = S_ISSUE1;
            end
            S_ISSUE1: begin
                sram_rd_en = 1'b1;
                addr_now   = CONV2_BIAS1_ADDR;
                next_state = S_LOAD0;
            end
            S_LOAD0: begin
                load_conv2_bias0_enable = 1'b1;
                next_state              = S_LOAD1;
            end
            S_LOAD1: begin
                load_conv2_bias1_enable = 1'b1;
                next_state              = S_SETTLE;
            end
            S_SETTLE: next_state = S_RUN;
            S_RUN: begin
                if (ch_advance) begin
                    if (cnt_last) next_state = S_DONE;
                    else          cnt_inc    = 1'b1;
                end
            end
            S_DONE: begin
                cnt_clr    = 1'b1;
                next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Channel 0 of CONV2 lives in bias word 0, loaded one cycle before word 1,
    // so the selector output is already valid during SETTLE on that path.
    assign bias_ready = ((state == S_RUN) && !inc_d) ||
                        ((state == S_SETTLE) && (mode_q == MODE_CONV2));

    assign sram_raddr_weight = addr_now;
    assign mode              = (state == S_IDLE) ? MODE_IDLE : mode_q;
    assign busy              = (state != S_IDLE);
    assign done              = (state == S_DONE);
    assign set               = count;
    assign conv1_bias_set    = {{(ADDR_W-IDX_W){1'b0}}, count};

`ifdef BIAS_CTRL_ERR_EN
    logic err_evt;
    assign err_evt = (ch_advance && (state != S_RUN)) ||
                     (start && (state != S_IDLE)) ||
                     (start && (state == S_IDLE) && !mode_valid(mode_in));

    always_ff @(posedge clk) begin
        if (srst) begin
            err <= 1'b0;
        end else if (err_evt) begin
            err <= 1'b1;
        end
    end
`endif

endmodule
